fp_pow_n: RTL and testbench



---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_pow_n_if.sv | 20 ++
 rtl/fp_mul_core.sv | 86 ++++++++
 rtl/fp_pow_n.sv | 78 +++++++
 tb/tb_fp_pow_n.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float definitions: field widths, constants,
// the packed float layout and the power-unit FSM state encoding.
package fp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned BIAS   = 127;

  localparam logic [WORD_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [WORD_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] FP_PINF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } pow_state_t;

endpackage

// File: rtl/fp_pow_n_if.sv
// Start/busy/done job bus for the integer-power unit.
//   start  : job request (master -> slave)
//   a      : float base    (master -> slave)
//   n      : integer power (master -> slave)
//   busy   : unit is stepping (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   result : a^n, held until the next accepted start (slave -> master)
interface fp_pow_n_if #(
  parameter int unsigned N_W = 8
);
  logic           start;
  logic [31:0]    a;
  logic [N_W-1:0] n;
  logic           busy;
  logic           done;
  logic [31:0]    result;

  modport master (output start, a, n, input busy, done, result);
  modport slave  (input start, a, n, output busy, done, result);
endinterface

// File: rtl/fp_mul_core.sv
// Combinational single-precision multiply, round-to-nearest-even.
// Denormal inputs read as zero, underflow flushes to signed zero,
// overflow saturates to signed Inf, NaN / Inf*0 give canonical qNaN.
//   a, b      : operands
//   product_c : a*b (combinational)
module fp_mul_core
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] product_c
);

  fp_t                  fa, fb;
  logic                 sign;
  logic                 zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [2*MANT_W-1:0]  prod;
  logic [MANT_W-1:0]    mant;
  logic                 guard, rnd, sticky, inc;
  logic [MANT_W:0]      mant_r;
  logic signed [9:0]    exp_sum, exp_n, exp_f;
  logic [FRAC_W-1:0]    frac_f;

  assign fa = fp_t'(a);
  assign fb = fp_t'(b);

  // Operand classification
  always_comb begin
    zero_a = (fa.exp == '0);
    zero_b = (fb.exp == '0);
    inf_a  = (fa.exp == '1) && (fa.frac == '0);
    inf_b  = (fb.exp == '1) && (fb.frac == '0);
    nan_a  = (fa.exp == '1) && (fa.frac != '0);
    nan_b  = (fb.exp == '1) && (fb.frac != '0);
    sign   = fa.sign ^ fb.sign;
  end

  // Mantissa product, 1-bit normalise, RNE round, carry renormalise
  always_comb begin
    prod    = 48'({1'b1, fa.frac}) * 48'({1'b1, fb.frac});
    exp_sum = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp})
              - $signed(10'(BIAS));
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      rnd    = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_sum + 10'sd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      rnd    = prod[21];
      sticky = |prod[20:0];
      exp_n  = exp_sum;
    end
    inc    = guard & (rnd | sticky | mant[0]);
    mant_r = {1'b0, mant} + 25'(inc);
    // Carry out of rounding leaves 1.000..0; bump the exponent.
    if (mant_r[24]) begin
      exp_f  = exp_n + 10'sd1;
      frac_f = mant_r[23:1];
    end else begin
      exp_f  = exp_n;
      frac_f = mant_r[22:0];
    end
  end

  // Special-case resolution
  always_comb begin
    product_c = FP_QNAN;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      product_c = FP_QNAN;
    end else if (inf_a || inf_b) begin
      product_c = {sign, FP_PINF[30:0]};
    end else if (zero_a || zero_b) begin
      product_c = {sign, 31'h0};
    end else if (exp_f >= 10'sd255) begin
      product_c = {sign, FP_PINF[30:0]};
    end else if (exp_f <= 10'sd0) begin
      product_c = {sign, 31'h0};
    end else begin
      product_c = {sign, exp_f[7:0], frac_f};
    end
  end

endmodule

// File: rtl/fp_pow_n.sv
// Sequential float integer power a^n: LSB-first square-and-multiply,
// one shared multiply per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/a/n in; busy/done/result out (fp_pow_n_if.slave)
module fp_pow_n
  import fp_pkg::*;
#(
  parameter int unsigned N_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  fp_pow_n_if.slave     bus
);

  pow_state_t        state;
  logic [WORD_W-1:0] acc, base, result;
  logic [N_W-1:0]    e;
  logic              busy, done;
  logic [WORD_W-1:0] mul_a, mul_y_c;

  // Odd exponent bit multiplies into acc, otherwise square the base.
  assign mul_a = e[0] ? acc : base;

  fp_mul_core u_mul (
    .a         (mul_a),
    .b         (base),
    .product_c (mul_y_c)
  );

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      base   <= '0;
      e      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            acc   <= FP_ONE;
            base  <= bus.a;
            e     <= bus.n;
            busy  <= 1'b1;
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (e == '0) begin
            result <= acc;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end else if (e[0]) begin
            acc  <= mul_y_c;
            e[0] <= 1'b0;
          end else begin
            base <= mul_y_c;
            e    <= e >> 1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;

endmodule

// File: tb/tb_fp_pow_n.sv
// Directed bench for fp_pow_n: vector table plus protocol sequences.
module tb_fp_pow_n;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_pow_n_if #(.N_W(8)) bus ();

  fp_pow_n #(.N_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [7:0]  n;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Caller is at a negedge. Returns at the negedge where done is seen.
  // With poke set, start is re-pulsed with junk inputs while busy.
  task automatic run_job(input string name, input logic [31:0] a,
                         input logic [7:0] n, input bit poke,
                         output logic [31:0] res, output int lat);
    bus.start = 1'b1;
    bus.a     = a;
    bus.n     = n;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.n     = 8'hA5;
    check({name, " busy_after_start"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 1) begin
        bus.start = 1'b1;
        bus.a     = 32'h4000_0000;
        bus.n     = 8'd5;
      end else if (poke && lat == 2) begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
      if (lat > 100) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: no done within 100 cycles", name);
        break;
      end
    end
    res = bus.result;
    check({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          seen_done;

    vecs[0]  = '{"p1_5_n3",    32'h3FC0_0000, 8'd3,   32'h4058_0000, 5};
    vecs[1]  = '{"m2_n3",      32'hC000_0000, 8'd3,   32'hC100_0000, 5};
    vecs[2]  = '{"m2_n2",      32'hC000_0000, 8'd2,   32'h4080_0000, 4};
    vecs[3]  = '{"nan_n0",     32'h7FFF_FFFF, 8'd0,   32'h3F80_0000, 2};
    vecs[4]  = '{"nan_n1",     32'h7FFF_FFFF, 8'd1,   32'h7FC0_0000, 3};
    vecs[5]  = '{"two_n128",   32'h4000_0000, 8'd128, 32'h7F80_0000, 10};
    vecs[6]  = '{"half_n150",  32'h3F00_0000, 8'd150, 32'h0000_0000, 13};
    vecs[7]  = '{"rne_n2",     32'h3F80_0001, 8'd2,   32'h3F80_0002, 4};
    vecs[8]  = '{"mzero_n2",   32'h8000_0000, 8'd2,   32'h0000_0000, 4};
    vecs[9]  = '{"inf_n0",     32'h7F80_0000, 8'd0,   32'h3F80_0000, 2};
    vecs[10] = '{"minf_n1",    32'hFF80_0000, 8'd1,   32'hFF80_0000, 3};
    vecs[11] = '{"zero_n3",    32'h0000_0000, 8'd3,   32'h0000_0000, 5};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.n     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   32'(bus.busy), 32'd0);
    check("reset done",   32'(bus.done), 32'd0);
    check("reset result", bus.result,    32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_job(vecs[i].name, vecs[i].a, vecs[i].n, 1'b0, res, lat);
      check({vecs[i].name, " result"},  res,     vecs[i].exp_r);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      @(negedge clk);
      check({vecs[i].name, " done_pulse"}, 32'(bus.done), 32'd0);
      check({vecs[i].name, " result_hold"}, bus.result, vecs[i].exp_r);
    end

    // start while busy must not disturb the running job
    run_job("poke", 32'h3FC0_0000, 8'd3, 1'b1, res, lat);
    check("poke result",  res,      32'h4058_0000);
    check("poke latency", 32'(lat), 32'd5);
    @(negedge clk);

    // back-to-back: new start presented in the done cycle
    run_job("b2b_first", 32'hC000_0000, 8'd3, 1'b0, res, lat);
    check("b2b_first result", res, 32'hC100_0000);
    run_job("b2b_second", 32'h3FC0_0000, 8'd3, 1'b0, res, lat);
    check("b2b_second result",  res,      32'h4058_0000);
    check("b2b_second latency", 32'(lat), 32'd5);
    @(negedge clk);

    // reset in the middle of stepping aborts without a done pulse
    bus.start = 1'b1;
    bus.a     = 32'h4000_0000;
    bus.n     = 8'd128;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst busy",   32'(bus.busy), 32'd0);
    check("mid_rst done",   32'(bus.done), 32'd0);
    check("mid_rst result", bus.result,    32'h0);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("mid_rst no_done", 32'(seen_done), 32'd0);

    run_job("recover", 32'hC000_0000, 8'd2, 1'b0, res, lat);
    check("recover result",  res,      32'h4080_0000);
    check("recover latency", 32'(lat), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
